mem_port_arbiter: RTL

Arbitrates one single-port shared memory between the instruction-fetch requester and the MEM-stage data requester in the multicycle MIPS core. It sits between both stages and the memory array, after address mapping. It sequences each access over a fixed latency, returns read data with a one-cycle ready pulse, and raises `freeze` to stall the pipeline while any request is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the shared-memory arbiter and the single-port SRAM.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_re;
  logic        sram_we;

  // Handshake: a requester raises its request level and holds it, with all fields stable,
  // until its ready pulses for one cycle; it must drop or change the request at the edge that ends that pulse.
  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_addr, sram_wdata, sram_re, sram_we
  );

  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_addr, sram_wdata, sram_re, sram_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage with a fixed access latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed MEM-over-IF priority.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      mem_rdata_q;
  logic             we_q;
  logic             gnt_mem;
  logic             mem_req;
  logic             pick_mem;
  logic             busy;
  logic             resp;

  assign mem_req = bus.mem_r_en | bus.mem_w_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_mem;

  // On contention the requester that did not win last time is granted.
  assign pick_mem = mem_req & (~bus.if_req | ~last_mem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_mem <= 1'b0;
    end else if (state == IDLE && (bus.if_req | mem_req)) begin
      last_mem <= pick_mem;
    end
  end
`else
  // MEM holds the older instruction, so it always wins.
  assign pick_mem = mem_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_mem     <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req | mem_req) begin
            gnt_mem <= pick_mem;
            addr_q  <= pick_mem ? bus.mem_addr : bus.if_addr;
            wdata_q <= pick_mem ? bus.mem_wdata : '0;
            we_q    <= pick_mem & bus.mem_w_en;
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (gnt_mem) mem_rdata_q <= bus.sram_rdata;
              else         if_rdata_q  <= bus.sram_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign resp = (state == RESP);

  assign bus.sram_addr  = busy ? addr_q : '0;
  assign bus.sram_wdata = (busy & we_q) ? wdata_q : '0;
  assign bus.sram_re    = busy & ~we_q;
  assign bus.sram_we    = busy & we_q;

  assign bus.if_ready   = resp & ~gnt_mem;
  assign bus.mem_ready  = resp & gnt_mem;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;

  assign bus.freeze = (bus.if_req & ~bus.if_ready) | (mem_req & ~bus.mem_ready);

  assign fsm_state = state;

endmodule
